seq_signed_multiplier: RTL and testbench
========================================

SEQ_SIGNED_MULTIPLIER -- requirements
Module: seq_signed_multiplier

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 Clock  input  1  rising-edge clock; sole clock of the block.
REQ-003 Reset  input  1  synchronous, active-low reset, sampled on the rising edge of Clock.
REQ-004 Start  input  1  request pulse; operands and mode are captured when the request is accepted.
REQ-005 inputA  input  WIDTH  multiplicand, raw bits.
REQ-006 inputB  input  WIDTH  multiplier, raw bits.
REQ-007 S0  input  1  1 = inputA is two's-complement signed; 0 = inputA is unsigned.
REQ-008 S1  input  1  1 = inputB is two's-complement signed; 0 = inputB is unsigned.
REQ-009 Busy  output  1  high while a multiplication is in progress.
REQ-010 Valid  output  1  one-cycle pulse marking a new result on Product.
REQ-011 Product  output  2*WIDTH+1  signed result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 IDLE with Start=1: latch inputA, inputB, S0 and S1; go to CALC; clear the iteration counter.
REQ-014 Each operand SHALL be extended to WIDTH+1 bits: sign-extended when its select bit is 1, zero-extended when it is 0.
REQ-015 CALC SHALL perform one radix-2 Booth step per cycle on the extended operands, for exactly WIDTH+1 cycles, then go to DONE.
REQ-016 DONE SHALL last one cycle, load Product, pulse Valid, and return to IDLE.
REQ-017 Latency: the first Valid pulse SHALL occur WIDTH+2 cycles after the cycle in which Start was accepted.
REQ-018 Busy SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-019 Start in CALC or DONE SHALL be ignored, with no queuing.
REQ-020 Start is only accepted in IDLE, so back-to-back requests have a throughput of one result per WIDTH+3 cycles.
REQ-021 Product SHALL hold its last value until the next DONE; inputs changing during CALC SHALL have no effect.
REQ-022 Product SHALL equal ext(A)*ext(B) exactly for all four modes, with no overflow; 2*WIDTH+1 bits covers every mode.
REQ-023 The internal accumulator SHALL be 2*WIDTH+2 bits wide; Product is its low 2*WIDTH+1 bits.

Reset
REQ-024 When Reset=0 at a clock edge: state IDLE, Busy=0, Valid=0, Product=0, and all internal registers cleared.
REQ-025 Reset asserted during CALC or DONE SHALL abort the operation with no Valid pulse.
REQ-026 Start is ignored in any cycle in which Reset=0.
REQ-027 Start on the first edge after Reset is released SHALL be accepted.

Structure
REQ-028 A shared package SHALL hold:
- the state encoding (IDLE/CALC/DONE);
- the mode constants MODE_UU=2'b00, MODE_SU=2'b01 (A signed), MODE_US=2'b10 (B signed), MODE_SS=2'b11, indexed as {S1,S0};
- the function computing the product width.
REQ-029 One sub-module, booth_step, SHALL be purely combinational. It takes the accumulator, the multiplicand and the Booth bit pair, and returns the next shifted accumulator.
REQ-030 The top level SHALL contain only the FSM, the counter and the registers.

Verification (WIDTH=4, inputA=4'b1101, inputB=4'b1001)
REQ-031 {S1,S0}=00 -> Product=+117; {S1,S0}=01 -> Product=-27.
REQ-032 {S1,S0}=10 -> Product=-91; {S1,S0}=11 -> Product=+21.
REQ-033 Corners in mode 11:
- A=4'b1000, B=4'b1000 -> +64;
- in mode 00, A=B=4'b1111 -> +225;
- A=4'b0000 -> Product=0.
REQ-034 Start pulsed at every cycle during CALC -> exactly one Valid pulse.
REQ-035 Measure latency: Valid rises exactly 6 cycles after Start is accepted; Busy is high for exactly 6 cycles.
REQ-036 Reset driven to 0 in the third CALC cycle:
- no Valid pulse;
- Product reads 0 and Busy reads 0 on the next edge;
- a new Start is then accepted and gives the correct result.

Source files
------------

// File: rtl/seq_signed_multiplier_pkg.sv
// Shared definitions for the sequential signed/unsigned Booth multiplier:
// FSM encoding, operand mode constants and the product width helper.
package seq_signed_multiplier_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Indexed as {S1, S0}
  localparam logic [1:0] MODE_UU = 2'b00;
  localparam logic [1:0] MODE_SU = 2'b01;
  localparam logic [1:0] MODE_US = 2'b10;
  localparam logic [1:0] MODE_SS = 2'b11;

  function automatic int prod_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/seq_signed_multiplier_if.sv
// Request/result bundle of the sequential multiplier.
interface seq_signed_multiplier_if
  import seq_signed_multiplier_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic                           Start;
  logic [WIDTH-1:0]               inputA;
  logic [WIDTH-1:0]               inputB;
  logic                           S0;
  logic                           S1;
  logic                           Busy;
  logic                           Valid;
  logic [prod_width(WIDTH)-1:0]   Product;

  modport master (
    output Start, inputA, inputB, S0, S1,
    input  Busy, Valid, Product
  );

  modport slave (
    input  Start, inputA, inputB, S0, S1,
    output Busy, Valid, Product
  );
endinterface

// File: rtl/seq_signed_multiplier_booth_step.sv
// One radix-2 Booth step: add/subtract the multiplicand into the upper half,
// then arithmetic-shift the whole accumulator right by one.
module booth_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH+1:0] acc,
  input  logic [WIDTH:0]     mcand,
  input  logic [1:0]         pair,
  output logic [2*WIDTH+1:0] acc_next,
  output logic               shift_out
);

  logic [WIDTH+1:0] hi;
  logic [WIDTH+1:0] m;
  logic [WIDTH+1:0] sum;

  // One guard bit keeps the add/subtract exact before the shift drops it back
  always_comb begin
    hi  = {acc[2*WIDTH+1], acc[2*WIDTH+1:WIDTH+1]};
    m   = {mcand[WIDTH], mcand};
    sum = hi;
    case (pair)
      2'b01:   sum = hi + m;
      2'b10:   sum = hi - m;
      default: sum = hi;
    endcase
  end

  assign {acc_next, shift_out} = {sum, acc[WIDTH:0]};

endmodule

// File: rtl/seq_signed_multiplier.sv
// Sequential multiplier with per-operand signedness; one Booth step per cycle
// over WIDTH+1-bit extended operands, result valid WIDTH+2 cycles after Start.
module seq_signed_multiplier
  import seq_signed_multiplier_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                    Clock,
  input logic                    Reset,
  seq_signed_multiplier_if.slave bus
);

  localparam int PW = prod_width(WIDTH);
  localparam int AW = PW + 1;
  localparam int CW = $clog2(WIDTH + 2);

  logic [1:0]       state;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_next;
  logic [WIDTH:0]   mcand;
  logic             q_prev;
  logic             shift_out;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    product;
  logic             valid;
  logic [1:0]       mode;
  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;
  logic             a_signed;
  logic             b_signed;

  always_comb begin
    mode     = {bus.S1, bus.S0};
    a_signed = (mode == MODE_SU) || (mode == MODE_SS);
    b_signed = (mode == MODE_US) || (mode == MODE_SS);
    ext_a    = {a_signed & bus.inputA[WIDTH-1], bus.inputA};
    ext_b    = {b_signed & bus.inputB[WIDTH-1], bus.inputB};
  end

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .mcand     (mcand),
    .pair      ({acc[0], q_prev}),
    .acc_next  (acc_next),
    .shift_out (shift_out)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      q_prev  <= 1'b0;
      cnt     <= '0;
      product <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            acc    <= AW'(ext_b);
            mcand  <= ext_a;
            q_prev <= 1'b0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          q_prev <= shift_out;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH)) state <= DONE;
        end
        DONE: begin
          product <= acc[PW-1:0];
          valid   <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy    = (state != IDLE);
  assign bus.Valid   = valid;
  assign bus.Product = product;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Scenario bench for seq_signed_multiplier (WIDTH=4) with an expected-result queue.
module tb_seq_signed_multiplier;

  localparam int W  = 4;
  localparam int PW = 2 * W + 1;

  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [PW-1:0] exp_q[$];

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  seq_signed_multiplier_if #(.WIDTH(W)) bus ();

  seq_signed_multiplier #(.WIDTH(W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s0, input logic s1);
    longint ea, eb, p;
    ea = s0 ? longint'($signed(a)) : longint'(a);
    eb = s1 ? longint'($signed(b)) : longint'(b);
    p  = ea * eb;
    return p[PW-1:0];
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s0, input logic s1, input logic [PW-1:0] expv);
    bus.Start  = 1'b1;
    bus.inputA = a;
    bus.inputB = b;
    bus.S0     = s0;
    bus.S1     = s1;
    exp_q.push_back(expv);
    @(negedge Clock);
    bus.Start = 1'b0;
  endtask

  task automatic wait_valid(output int n, output int busy_n, output bit seen);
    n = 0; busy_n = 0; seen = 1'b0;
    while (n < 20) begin
      if (bus.Valid) begin
        seen = 1'b1;
        break;
      end
      if (bus.Busy) busy_n++;
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    bus.Start = 1'b1;
    bus.inputA = 4'b0101; bus.inputB = 4'b0011; bus.S0 = 1'b0; bus.S1 = 1'b0;
    repeat (3) @(negedge Clock);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.Valid); end
    checks++; if (bus.Product !== '0) begin errors++; $display("FAIL reset_product got %0d want 0", bus.Product); end
    bus.Start = 1'b0;
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_modes;
    logic [1:0]    modes [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [PW-1:0] want  [4] = '{9'd117, -9'sd27, -9'sd91, 9'd21};
    int n, bn; bit seen; logic [PW-1:0] e;
    for (int i = 0; i < 4; i++) begin
      issue(4'b1101, 4'b1001, modes[i][0], modes[i][1], want[i]);
      wait_valid(n, bn, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin errors++; $display("FAIL mode%0d timeout no Valid", i); end
      else if (bus.Product !== e) begin
        errors++; $display("FAIL mode%0d product got %0d want %0d", i, $signed(bus.Product), $signed(e));
      end
    end
  endtask

  task automatic test_corners;
    logic [W-1:0]  ta   [3] = '{4'b1000, 4'b1111, 4'b0000};
    logic [W-1:0]  tb_  [3] = '{4'b1000, 4'b1111, 4'b1011};
    logic [1:0]    tm   [3] = '{2'b11, 2'b00, 2'b11};
    logic [PW-1:0] want [3] = '{9'd64, 9'd225, 9'd0};
    int n, bn; bit seen; logic [PW-1:0] e;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb_[i], tm[i][0], tm[i][1], want[i]);
      wait_valid(n, bn, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin errors++; $display("FAIL corner%0d timeout no Valid", i); end
      else if (bus.Product !== e) begin
        errors++; $display("FAIL corner%0d product got %0d want %0d", i, $signed(bus.Product), $signed(e));
      end
    end
  endtask

  task automatic test_latency;
    int n, bn; bit seen; logic [PW-1:0] e;
    issue(4'b1101, 4'b1001, 1'b1, 1'b1, 9'd21);
    wait_valid(n, bn, seen);
    e = exp_q.pop_front();
    checks++; if (!seen || n != 6) begin errors++; $display("FAIL latency got %0d want 6", n); end
    checks++; if (bn != 6) begin errors++; $display("FAIL busy_cycles got %0d want 6", bn); end
    checks++; if (bus.Product !== e) begin errors++; $display("FAIL latency_product got %0d want %0d", bus.Product, e); end
    @(negedge Clock);
    checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL valid_width got %b want 0", bus.Valid); end
  endtask

  task automatic test_start_ignored;
    int valids = 0; logic [PW-1:0] got = '0; logic [PW-1:0] e;
    issue(4'b0111, 4'b0011, 1'b0, 1'b0, 9'd21);
    for (int k = 0; k < 20; k++) begin
      if (bus.Valid) begin valids++; got = bus.Product; end
      bus.Start  = bus.Busy;
      bus.inputA = W'($urandom);
      bus.inputB = W'($urandom);
      bus.S0     = 1'($urandom);
      bus.S1     = 1'($urandom);
      @(negedge Clock);
    end
    bus.Start = 1'b0;
    e = exp_q.pop_front();
    checks++; if (valids != 1) begin errors++; $display("FAIL ignore_start valids got %0d want 1", valids); end
    checks++; if (got !== e) begin errors++; $display("FAIL ignore_start product got %0d want %0d", got, e); end
  endtask

  task automatic test_back_to_back;
    int n, bn, last = 0; bit seen; logic [PW-1:0] e;
    logic [W-1:0] a, b; logic s0, s1;
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom); b = W'($urandom); s0 = 1'($urandom); s1 = 1'($urandom);
      issue(a, b, s0, s1, model(a, b, s0, s1));
      wait_valid(n, bn, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin errors++; $display("FAIL b2b%0d timeout no Valid", i); end
      else if (bus.Product !== e) begin
        errors++; $display("FAIL b2b%0d product got %0d want %0d (a=%b b=%b s1s0=%b%b)",
                           i, $signed(bus.Product), $signed(e), a, b, s1, s0);
      end
      if (i > 0) begin
        checks++;
        if (cyc - last != W + 3) begin errors++; $display("FAIL b2b%0d spacing got %0d want %0d", i, cyc - last, W + 3); end
      end
      last = cyc;
    end
  endtask

  task automatic test_reset_abort;
    int n, bn; bit seen; logic [PW-1:0] e;
    issue(4'b1101, 4'b1001, 1'b0, 1'b0, 9'd117);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    exp_q.delete();
    checks++; if (bus.Product !== '0) begin errors++; $display("FAIL abort_product got %0d want 0", bus.Product); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.Busy); end
    checks++; if (bus.Valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", bus.Valid); end
    Reset = 1'b1;
    issue(4'b1000, 4'b0111, 1'b1, 1'b0, model(4'b1000, 4'b0111, 1'b1, 1'b0));
    wait_valid(n, bn, seen);
    e = exp_q.pop_front();
    checks++; if (!seen || n != 6) begin errors++; $display("FAIL abort_restart latency got %0d want 6", n); end
    checks++; if (bus.Product !== e) begin errors++; $display("FAIL abort_restart product got %0d want %0d", $signed(bus.Product), $signed(e)); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Start = 1'b0; bus.inputA = '0; bus.inputB = '0; bus.S0 = 1'b0; bus.S1 = 1'b0;
    Reset = 1'b0;
    @(negedge Clock);
    test_reset();
    test_modes();
    test_corners();
    test_latency();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
